// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller for the iterative divider in the EX stage.
// It launches the external divider core, stalls EX while the core runs and
// captures the result. The result is held until EX may advance, and HI/LO are
// written once per committed divide.
// Handshake: div_start is a one-cycle launch pulse, and the core samples
// div_opa/div_opb/div_signed in that cycle. div_ready is a one-cycle result
// pulse that is honoured only in BUSY. div_annul is a one-cycle abort pulse,
// raised combinationally in the BUSY cycle where flushE is seen.
module div_ctrl #(
    parameter logic [31:0] ZERO_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        divsignalE,
    input  logic        signeddivsignalE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        stallE,
    input  logic        flushE,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        stall_div,
    output logic [1:0]  hilowriteE,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_start;
    logic        r_signed;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_div_zero;
    logic        w_write;

    // A divide is accepted only from IDLE and only when it is not being squashed
    assign w_accept   = (r_state == S_IDLE) && divsignalE && !flushE;
    assign w_div_zero = (srcbE == 32'd0);

    // Commit happens in DONE on the cycle EX is free to advance and not flushed
    assign w_write    = (r_state == S_DONE) && !stallE && !flushE;

    // Main FSM: launch, wait for the core, hold the result until commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_start  <= 1'b0;
            r_signed <= 1'b0;
            r_opa    <= 32'd0;
            r_opb    <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_div_zero) begin
                            // Divide-by-zero bypasses the core entirely
                            r_hi    <= srcaE;
                            r_lo    <= ZERO_LO;
                            r_state <= S_DONE;
                        end else begin
                            r_opa    <= srcaE;
                            r_opb    <= srcbE;
                            r_signed <= signeddivsignalE;
                            r_start  <= 1'b1;
                            r_state  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // A flush wins over a coincident result
                    if (flushE) begin
                        r_state <= S_IDLE;
                    end else if (div_ready) begin
                        r_hi    <= div_result[63:32];
                        r_lo    <= div_result[31:0];
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flushE || !stallE) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign div_start   = r_start;
    assign div_signed  = r_signed;
    assign div_opa     = r_opa;
    assign div_opb     = r_opb;
    assign hi_o        = r_hi;
    assign lo_o        = r_lo;
    assign o_dbg_state = r_state;

    // Abort is suppressed while reset is active; the core is reset separately
    assign div_annul   = (r_state == S_BUSY) && flushE && !rst;
    assign stall_div   = w_accept || (r_state == S_BUSY);
    assign hilowriteE  = {2{w_write}};

endmodule
